// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the warp fetch unit.
// Fetch entries are packed {kill, warp, pc, inst}, MSB first.
package fetch_pkg;

  localparam int INST_WIDTH_DEF = 16;
  localparam int PC_WIDTH_DEF   = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
// N must be a power of two so the index wraps by truncation.
module rr_arbiter
  import fetch_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[PW'(ptr + PW'(i))]) begin
        gnt[PW'(ptr + PW'(i))] = 1'b1;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_fetch_unit.sv
// Multi-warp fetch: RR issue to a 1-cycle imem, tagged FIFO, per-warp flush.
// Define WARP_FETCH_PERF_EN to add saturating grant/stall counters.
module warp_fetch_unit
  import fetch_pkg::*;
#(
  parameter  int INST_WIDTH = INST_WIDTH_DEF,
  parameter  int PC_WIDTH   = PC_WIDTH_DEF,
  parameter  int NUM_WARPS  = 4,
  parameter  int BUF_DEPTH  = 4,
  localparam int WID_W      = clog2(NUM_WARPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WARPS-1:0]          fetch_req,
  input  logic [NUM_WARPS*PC_WIDTH-1:0] fetch_pc,
  output logic [NUM_WARPS-1:0]          fetch_ack,
  input  logic [NUM_WARPS-1:0]          flush,
  output logic                          mem_rd_en,
  output logic [PC_WIDTH-1:0]           mem_rd_addr,
  input  logic [INST_WIDTH-1:0]         mem_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INST_WIDTH-1:0]         out_inst,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic [WID_W-1:0]              out_warp
`ifdef WARP_FETCH_PERF_EN
  ,
  output logic [31:0]                   perf_fetches,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int PTR_W = clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                  kill;
    logic [WID_W-1:0]      warp;
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t              buf_q [BUF_DEPTH];
  entry_t              buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                infl_q, infl_d;
  logic [PC_WIDTH-1:0] infl_pc_q, infl_pc_d;
  logic [WID_W-1:0]    infl_warp_q, infl_warp_d;
  logic [WID_W-1:0]    rr_q, rr_d;

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] gnt;
  logic                 any;
  logic                 can_issue;
  logic                 grant;
  logic [WID_W-1:0]     g_idx;
  logic [PC_WIDTH-1:0]  sel_pc;
  logic                 push;
  logic                 pop;
  logic                 present;
  entry_t               head;

  assign eligible = fetch_req & ~flush;

  rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .req (eligible),
    .ptr (rr_q),
    .gnt (gnt),
    .any (any)
  );

  // Registered count only, so out_ready never reaches fetch_ack.
  assign can_issue = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(infl_q))
                     < (CNT_W+1)'(BUF_DEPTH);
  assign grant     = any && can_issue && !rst;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (gnt[i]) g_idx = WID_W'(i);
    end
  end

  assign sel_pc = fetch_pc[g_idx*PC_WIDTH +: PC_WIDTH];

  assign head    = buf_q[rd_ptr_q];
  assign present = (cnt_q != '0);
  assign push    = infl_q && !flush[infl_warp_q];
  assign pop     = present && (head.kill || out_ready);

  always_comb begin
    fetch_ack   = grant ? gnt : '0;
    mem_rd_en   = grant;
    mem_rd_addr = grant ? sel_pc : '0;
    out_valid   = present && !head.kill;
    out_inst    = out_valid ? head.inst : '0;
    out_pc      = out_valid ? head.pc : '0;
    out_warp    = out_valid ? head.warp : '0;
  end

  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      buf_d[i]      = buf_q[i];
      buf_d[i].kill = buf_q[i].kill | flush[buf_q[i].warp];
    end
    if (push) begin
      buf_d[wr_ptr_q].kill = 1'b0;
      buf_d[wr_ptr_q].warp = infl_warp_q;
      buf_d[wr_ptr_q].pc   = infl_pc_q;
      buf_d[wr_ptr_q].inst = mem_rd_data;
    end
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    infl_d      = grant;
    infl_pc_d   = grant ? sel_pc : infl_pc_q;
    infl_warp_d = grant ? g_idx : infl_warp_q;
    rr_d        = grant ? WID_W'(g_idx + 1'b1) : rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_pc_q   <= '0;
      infl_warp_q <= '0;
      rr_q        <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= buf_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_pc_q   <= infl_pc_d;
      infl_warp_q <= infl_warp_d;
      rr_q        <= rr_d;
    end
  end

`ifdef WARP_FETCH_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall;

  assign stall = (|eligible) && !can_issue;

  always_comb begin
    perf_fetches_d = perf_fetches_q;
    perf_stall_d   = perf_stall_q;
    if (grant && !(&perf_fetches_q)) perf_fetches_d = perf_fetches_q + 32'd1;
    if (stall && !(&perf_stall_q))   perf_stall_d   = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetches_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
